// File: rtl/seg_scan_decoder.sv
// Receive side of a multiplexed 7-segment display bus. This block samples the
// AN/SEG lines, waits for each digit to settle, and decodes its glyph back to a
// nibble. Once digits 0..7 have all been collected, it publishes the 32-bit word.
module seg_scan_decoder #(
    parameter int unsigned STABLE_CYCLES = 4,
    parameter int unsigned TIMEOUT       = 65536
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  AN,
    input  logic [7:0]  SEG,
    output logic [31:0] value,
    output logic        value_valid,
    output logic        glyph_err,
    output logic        timeout_err
);

    localparam int unsigned StabW = $clog2(STABLE_CYCLES + 1);
    localparam int unsigned ToW   = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {StWaitSync, StCollect, StPublish} state_e;

    state_e            state_q, state_d;
    logic [7:0]        an_q, seg_q, an_p, seg_p;
    logic [StabW-1:0]  stab_cnt_q, stab_cnt_d;
    logic [ToW-1:0]    to_cnt_q, to_cnt_d;
    logic [7:0]        mask_q, mask_d;
    logic [31:0]       buf_q, buf_d;
    logic [31:0]       value_q;
    logic              value_valid_q, glyph_err_q, timeout_err_q;

    logic              same, settled;
    logic [3:0]        zcnt;
    logic [2:0]        didx;
    logic [3:0]        nib;
    logic              gvalid;
    logic              dig_ok, err_ev, to_ev, publish;

    // Input stage plus a delayed copy for the stability compare; idle is all-blank.
    always_ff @(posedge clk) begin
        if (rst) begin
            an_q  <= 8'hFF;
            seg_q <= 8'hFF;
            an_p  <= 8'hFF;
            seg_p <= 8'hFF;
        end else begin
            an_q  <= AN;
            seg_q <= SEG;
            an_p  <= an_q;
            seg_p <= seg_q;
        end
    end

    // Stability counter saturates one past the settle point so each pattern fires once.
    always_comb begin
        same       = ({an_q, seg_q} == {an_p, seg_p});
        stab_cnt_d = stab_cnt_q;
        if (!same) begin
            stab_cnt_d = '0;
        end else if (stab_cnt_q != StabW'(STABLE_CYCLES)) begin
            stab_cnt_d = stab_cnt_q + 1'b1;
        end
        settled = same && (stab_cnt_q == StabW'(STABLE_CYCLES - 1));
    end

    // Classify AN (blank / single digit / multiple) and decode the active-low glyph.
    always_comb begin
        zcnt = '0;
        didx = '0;
        for (int i = 0; i < 8; i++) begin
            if (!an_q[i]) begin
                zcnt = zcnt + 4'd1;
                didx = 3'(i);
            end
        end
        gvalid = 1'b1;
        case (seg_q[6:0])
            7'h40:   nib = 4'h0;
            7'h79:   nib = 4'h1;
            7'h24:   nib = 4'h2;
            7'h30:   nib = 4'h3;
            7'h19:   nib = 4'h4;
            7'h12:   nib = 4'h5;
            7'h02:   nib = 4'h6;
            7'h78:   nib = 4'h7;
            7'h00:   nib = 4'h8;
            7'h10:   nib = 4'h9;
            7'h08:   nib = 4'hA;
            7'h03:   nib = 4'hB;
            7'h46:   nib = 4'hC;
            7'h21:   nib = 4'hD;
            7'h06:   nib = 4'hE;
            7'h0E:   nib = 4'hF;
            default: begin
                nib    = 4'h0;
                gvalid = 1'b0;
            end
        endcase
        dig_ok = settled && (zcnt == 4'd1) && gvalid;
        err_ev = settled && ((zcnt > 4'd1) || ((zcnt == 4'd1) && !gvalid));
    end

    // Frame assembly FSM: sync on digit 0, collect all eight, publish for one cycle.
    always_comb begin
        state_d  = state_q;
        mask_d   = mask_q;
        buf_d    = buf_q;
        to_cnt_d = '0;
        to_ev    = 1'b0;
        publish  = 1'b0;
        case (state_q)
            StWaitSync: begin
                if (dig_ok && (didx == 3'd0)) begin
                    buf_d[3:0] = nib;
                    mask_d     = 8'h01;
                    state_d    = StCollect;
                end
            end
            StCollect: begin
                to_ev    = (to_cnt_q == ToW'(TIMEOUT - 1));
                to_cnt_d = to_ev ? to_cnt_q : to_cnt_q + 1'b1;
                // Errors and timeout take priority over a completing digit.
                if (err_ev || to_ev) begin
                    mask_d   = '0;
                    to_cnt_d = '0;
                    state_d  = StWaitSync;
                end else if (dig_ok) begin
                    buf_d[{didx, 2'b00} +: 4] = nib;
                    mask_d   = mask_q | (8'h01 << didx);
                    to_cnt_d = '0;
                    if (mask_d == 8'hFF) begin
                        state_d = StPublish;
                    end
                end
            end
            StPublish: begin
                publish = 1'b1;
                mask_d  = '0;
                state_d = StWaitSync;
            end
            default: begin
                mask_d  = '0;
                state_d = StWaitSync;
            end
        endcase
    end

    // State, frame buffer and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= StWaitSync;
            stab_cnt_q    <= '0;
            to_cnt_q      <= '0;
            mask_q        <= '0;
            buf_q         <= '0;
            value_q       <= '0;
            value_valid_q <= 1'b0;
            glyph_err_q   <= 1'b0;
            timeout_err_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            stab_cnt_q    <= stab_cnt_d;
            to_cnt_q      <= to_cnt_d;
            mask_q        <= mask_d;
            buf_q         <= buf_d;
            if (publish) begin
                value_q <= buf_q;
            end
            value_valid_q <= publish;
            glyph_err_q   <= err_ev;
            timeout_err_q <= to_ev;
        end
    end

    assign value       = value_q;
    assign value_valid = value_valid_q;
    assign glyph_err   = glyph_err_q;
    assign timeout_err = timeout_err_q;

endmodule

// File: tb/tb_seg_scan_decoder.sv
// Directed bench for seg_scan_decoder. Pulses are counted by a negedge monitor
// and compared per scenario against hand-computed expectations.
module tb_seg_scan_decoder;

    localparam int unsigned StableCycles = 4;
    localparam int unsigned Timeout      = 300;

    logic        clk;
    logic        rst;
    logic [7:0]  AN;
    logic [7:0]  SEG;
    logic [31:0] value;
    logic        value_valid;
    logic        glyph_err;
    logic        timeout_err;

    int n_cmp = 0;
    int n_err = 0;
    int vv_n  = 0;
    int ge_n  = 0;
    int te_n  = 0;
    int vv0, ge0, te0;

    seg_scan_decoder #(
        .STABLE_CYCLES(StableCycles),
        .TIMEOUT      (Timeout)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .AN         (AN),
        .SEG        (SEG),
        .value      (value),
        .value_valid(value_valid),
        .glyph_err  (glyph_err),
        .timeout_err(timeout_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Pulse counters, sampled away from the rising edge.
    always @(negedge clk) begin
        if (value_valid) vv_n <= vv_n + 1;
        if (glyph_err)   ge_n <= ge_n + 1;
        if (timeout_err) te_n <= te_n + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [6:0] enc(input logic [3:0] n);
        case (n)
            4'h0: enc = 7'h40;  4'h1: enc = 7'h79;  4'h2: enc = 7'h24;  4'h3: enc = 7'h30;
            4'h4: enc = 7'h19;  4'h5: enc = 7'h12;  4'h6: enc = 7'h02;  4'h7: enc = 7'h78;
            4'h8: enc = 7'h00;  4'h9: enc = 7'h10;  4'hA: enc = 7'h08;  4'hB: enc = 7'h03;
            4'hC: enc = 7'h46;  4'hD: enc = 7'h21;  4'hE: enc = 7'h06;  default: enc = 7'h0E;
        endcase
    endfunction

    task automatic drive(input logic [7:0] an, input logic [7:0] seg, input int hold);
        @(negedge clk);
        AN  = an;
        SEG = seg;
        repeat (hold - 1) @(negedge clk);
    endtask

    task automatic scan_digit(input int i, input logic [3:0] n, input int hold);
        logic [7:0] an;
        an = 8'hFF;
        an[i] = 1'b0;
        drive(an, {1'b1, enc(n)}, hold);
    endtask

    task automatic blank(input int hold);
        drive(8'hFF, 8'hFF, hold);
    endtask

    task automatic scan_frame(input logic [31:0] w, input int gap);
        for (int i = 0; i < 8; i++) begin
            scan_digit(i, w[4*i +: 4], 10);
            if (gap > 0) blank(gap);
        end
        blank(8);
    endtask

    task automatic snap();
        vv0 = vv_n;
        ge0 = ge_n;
        te0 = te_n;
    endtask

    initial begin
        rst = 1'b1;
        AN  = 8'hFF;
        SEG = 8'hFF;
        repeat (3) @(negedge clk);
        check("rst_value", value, 32'h0);
        check("rst_valid", 32'(value_valid), 32'h0);
        check("rst_gerr", 32'(glyph_err), 32'h0);
        check("rst_terr", 32'(timeout_err), 32'h0);
        rst = 1'b0;
        blank(5);

        // 1: clean frame
        snap();
        scan_frame(32'h1234ABCD, 0);
        check("t1_value", value, 32'h1234ABCD);
        check("t1_vv", 32'(vv_n - vv0), 32'd1);
        check("t1_ge", 32'(ge_n - ge0), 32'd0);
        check("t1_te", 32'(te_n - te0), 32'd0);

        // 2: digit 3 held only STABLE_CYCLES-1 cycles, frame stalls and times out
        snap();
        for (int i = 0; i < 8; i++) begin
            scan_digit(i, 4'(i + 1), (i == 3) ? StableCycles - 1 : 10);
        end
        blank(2 * Timeout);
        check("t2_te", 32'(te_n - te0), 32'd1);
        check("t2_vv", 32'(vv_n - vv0), 32'd0);
        check("t2_value", value, 32'h1234ABCD);

        // 3: unknown glyph on digit 3, then clean frame
        snap();
        for (int i = 0; i < 8; i++) begin
            if (i == 3) drive(8'hF7, 8'hFF, 10);
            else        scan_digit(i, 4'h5, 10);
        end
        blank(8);
        check("t3_ge", 32'(ge_n - ge0), 32'd1);
        check("t3_vv", 32'(vv_n - vv0), 32'd0);
        check("t3_value_hold", value, 32'h1234ABCD);
        snap();
        scan_frame(32'h00000008, 0);
        check("t3_value", value, 32'h00000008);
        check("t3_vv2", 32'(vv_n - vv0), 32'd1);

        // 4: two digits enabled at once, then a frame with blanks between digits
        snap();
        scan_digit(0, 4'h3, 10);
        drive(8'hFC, {1'b1, enc(4'h3)}, 10);
        blank(8);
        check("t4_ge", 32'(ge_n - ge0), 32'd1);
        check("t4_vv", 32'(vv_n - vv0), 32'd0);
        snap();
        scan_frame(32'h89ABCDEF, 10);
        check("t4_ge_blank", 32'(ge_n - ge0), 32'd0);
        check("t4_vv2", 32'(vv_n - vv0), 32'd1);
        check("t4_value", value, 32'h89ABCDEF);

        // 5: scan starts mid-frame at digit 5
        snap();
        for (int i = 5; i < 8; i++) scan_digit(i, 4'(32'hDEADBEEF >> (4 * i)), 10);
        check("t5_vv_early", 32'(vv_n - vv0), 32'd0);
        scan_frame(32'hDEADBEEF, 0);
        check("t5_vv", 32'(vv_n - vv0), 32'd1);
        check("t5_value", value, 32'hDEADBEEF);
        check("t5_ge", 32'(ge_n - ge0), 32'd0);

        // 6: reset mid-frame discards partial progress
        for (int i = 0; i < 5; i++) scan_digit(i, 4'(i), 10);
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        check("t6_rst_value", value, 32'h0);
        check("t6_rst_valid", 32'(value_valid), 32'h0);
        rst = 1'b0;
        snap();
        for (int i = 5; i < 8; i++) scan_digit(i, 4'hF, 10);
        blank(8);
        check("t6_no_partial", 32'(vv_n - vv0), 32'd0);
        check("t6_value_zero", value, 32'h0);
        snap();
        scan_frame(32'hFFFFFFFF, 0);
        check("t6_vv", 32'(vv_n - vv0), 32'd1);
        check("t6_value", value, 32'hFFFFFFFF);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
